byte_lane_memory: RTL

- Parametrised, handshaked successor to the single-cycle byte-array data memory.
- Storage is word-organised with per-byte write enables.
- Adds valid/ready request and response channels, programmable read latency, automatic two-beat splitting of misaligned accesses, and out-of-range/illegal-type error reporting.
- Sits between the CPU load/store stage and on-chip RAM.

---
 rtl/byte_lane_memory_if.sv | 47 ++++
 rtl/byte_lane_memory.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_lane_memory_if.sv
// rtl/byte_lane_memory_if.sv - request/response bus between the load/store stage and byte_lane_memory
interface byte_lane_memory_if #(
    parameter int XLEN         = 32,
    parameter int LS_SEL_WIDTH = 3
);
    logic                    i_Req_Valid;
    logic                    o_Req_Ready;
    logic                    i_Write_Enable;
    logic [LS_SEL_WIDTH:0]   i_Load_Store_Type;
    logic [XLEN-1:0]         i_Addr;
    logic [XLEN-1:0]         i_Data;
    logic                    o_Rsp_Valid;
    logic                    i_Rsp_Ready;
    logic [XLEN-1:0]         o_Rsp_Data;
    logic                    o_Rsp_Error;
    logic                    o_Rsp_Split;

    // Load/store stage side
    modport master (
        output i_Req_Valid,
        input  o_Req_Ready,
        output i_Write_Enable,
        output i_Load_Store_Type,
        output i_Addr,
        output i_Data,
        input  o_Rsp_Valid,
        output i_Rsp_Ready,
        input  o_Rsp_Data,
        input  o_Rsp_Error,
        input  o_Rsp_Split
    );

    // Memory side
    modport slave (
        input  i_Req_Valid,
        output o_Req_Ready,
        input  i_Write_Enable,
        input  i_Load_Store_Type,
        input  i_Addr,
        input  i_Data,
        output o_Rsp_Valid,
        input  i_Rsp_Ready,
        output o_Rsp_Data,
        output o_Rsp_Error,
        output o_Rsp_Split
    );
endinterface

// File: rtl/byte_lane_memory.sv
// rtl/byte_lane_memory.sv - handshaked word-organised data memory with byte lanes and misaligned split
module byte_lane_memory #(
    parameter int MEMORY_DEPTH = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    byte_lane_memory_if.slave bus
);
    localparam int XLEN   = 32;
    localparam int WORDS  = MEMORY_DEPTH / 4;
    localparam int AW     = $clog2(WORDS);
    localparam int CNT_W  = 3;

    // Load/store type encoding shared with the load/store stage
    localparam logic [3:0] LS_TYPE_LOAD_BYTE          = 4'd0;
    localparam logic [3:0] LS_TYPE_LOAD_HALF          = 4'd1;
    localparam logic [3:0] LS_TYPE_LOAD_WORD          = 4'd2;
    localparam logic [3:0] LS_TYPE_LOAD_BYTE_UNSIGNED = 4'd4;
    localparam logic [3:0] LS_TYPE_LOAD_HALF_UNSIGNED = 4'd5;
    localparam logic [3:0] LS_TYPE_STORE_BYTE         = 4'd8;
    localparam logic [3:0] LS_TYPE_STORE_HALF         = 4'd9;
    localparam logic [3:0] LS_TYPE_STORE_WORD         = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_WAIT,
        S_RESP
    } state_t;

    // Word storage; deliberately never cleared by reset
    logic [XLEN-1:0]   mem_q [WORDS];

    state_t            state_q;
    logic              ready_q;
    logic [AW-1:0]     word_q;
    logic [1:0]        off_q;
    logic [2:0]        size_q;
    logic              signed_q;
    logic              we_q;
    logic              err_q;
    logic              split_q;
    logic [7:0]        be_q;
    logic [2*XLEN-1:0] wdata_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   hi_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              rsp_err_q;
    logic              rsp_split_q;

    logic [2:0]        dec_size;
    logic              dec_signed;
    logic              dec_legal;
    logic [3:0]        dec_mask;
    logic [1:0]        acc_off;
    logic              acc_split;
    logic [XLEN:0]     acc_end;
    logic              acc_err;
    logic [7:0]        acc_be;
    logic [2*XLEN-1:0] acc_wdata;

    logic [AW-1:0]     acc_idx;
    logic [XLEN-1:0]   rd_word;
    logic              wr_en;
    logic [3:0]        wr_be;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   win_lo_d;
    logic [XLEN-1:0]   win_hi_d;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_val;
    logic              beat_done;
    logic              go_wait;
    logic              go_resp;

    // Decode access size, signedness and type/direction legality of the incoming request
    always_comb begin
        dec_size   = 3'd4;
        dec_signed = 1'b0;
        dec_legal  = 1'b0;
        case (bus.i_Load_Store_Type)
            LS_TYPE_LOAD_BYTE: begin
                dec_size   = 3'd1;
                dec_signed = 1'b1;
                dec_legal  = !bus.i_Write_Enable;
            end
            LS_TYPE_LOAD_HALF: begin
                dec_size   = 3'd2;
                dec_signed = 1'b1;
                dec_legal  = !bus.i_Write_Enable;
            end
            LS_TYPE_LOAD_WORD: begin
                dec_size   = 3'd4;
                dec_legal  = !bus.i_Write_Enable;
            end
            LS_TYPE_LOAD_BYTE_UNSIGNED: begin
                dec_size   = 3'd1;
                dec_legal  = !bus.i_Write_Enable;
            end
            LS_TYPE_LOAD_HALF_UNSIGNED: begin
                dec_size   = 3'd2;
                dec_legal  = !bus.i_Write_Enable;
            end
            LS_TYPE_STORE_BYTE: begin
                dec_size   = 3'd1;
                dec_legal  = bus.i_Write_Enable;
            end
            LS_TYPE_STORE_HALF: begin
                dec_size   = 3'd2;
                dec_legal  = bus.i_Write_Enable;
            end
            LS_TYPE_STORE_WORD: begin
                dec_size   = 3'd4;
                dec_legal  = bus.i_Write_Enable;
            end
            default: begin
                dec_size   = 3'd4;
            end
        endcase
    end

    // Split, range (one extra bit so address wrap is caught), byte enables and lane-aligned store data
    always_comb begin
        acc_off   = bus.i_Addr[1:0];
        acc_split = ({2'b00, acc_off} + {1'b0, dec_size}) > 4'd4;
        acc_end   = {1'b0, bus.i_Addr} + {{(XLEN-2){1'b0}}, dec_size} - {{XLEN{1'b0}}, 1'b1};
        acc_err   = !dec_legal || (acc_end >= (XLEN+1)'(MEMORY_DEPTH));
        case (dec_size)
            3'd1:    dec_mask = 4'b0001;
            3'd2:    dec_mask = 4'b0011;
            default: dec_mask = 4'b1111;
        endcase
        acc_be    = {4'b0000, dec_mask} << acc_off;
        acc_wdata = {{XLEN{1'b0}}, bus.i_Data} << {acc_off, 3'b000};
    end

    // Beat addressing: BEAT0 touches the base word, BEAT1 the following word (upper window lanes)
    always_comb begin
        acc_idx = (state_q == S_BEAT1) ? (word_q + AW'(1)) : word_q;
        rd_word = mem_q[acc_idx];
        wr_en   = !i_Reset && we_q && !err_q && ((state_q == S_BEAT0) || (state_q == S_BEAT1));
        wr_be   = (state_q == S_BEAT1) ? be_q[7:4] : be_q[3:0];
        wr_data = (state_q == S_BEAT1) ? wdata_q[2*XLEN-1:XLEN] : wdata_q[XLEN-1:0];
    end

    // Load window update and extraction; the result is taken from the window as it will be after this edge
    always_comb begin
        win_lo_d = lo_q;
        win_hi_d = hi_q;
        if (state_q == S_BEAT0) win_lo_d = rd_word;
        if (state_q == S_BEAT1) win_hi_d = rd_word;
        shifted = XLEN'({win_hi_d, win_lo_d} >> {off_q, 3'b000});
        case (size_q)
            3'd1:    load_val = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'h000000, shifted[7:0]};
            3'd2:    load_val = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0000, shifted[15:0]};
            default: load_val = shifted;
        endcase
        if (we_q || err_q) load_val = '0;
    end

    // Sequencing after the last beat: either count down in WAIT or respond immediately
    always_comb begin
        beat_done = ((state_q == S_BEAT0) && !split_q) || (state_q == S_BEAT1);
        go_wait   = beat_done && (READ_LATENCY > 1);
        go_resp   = (beat_done && (READ_LATENCY == 1)) ||
                    ((state_q == S_WAIT) && (wait_cnt_q == '0));
    end

    // Per-byte word writes; a reset in the same cycle blocks the beat
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            word_q      <= '0;
            off_q       <= '0;
            size_q      <= 3'd4;
            signed_q    <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_split_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.i_Req_Valid && ready_q) begin
                        ready_q  <= 1'b0;
                        word_q   <= bus.i_Addr[AW+1:2];
                        off_q    <= acc_off;
                        size_q   <= dec_size;
                        signed_q <= dec_signed;
                        we_q     <= bus.i_Write_Enable;
                        err_q    <= acc_err;
                        split_q  <= acc_split && !acc_err;
                        be_q     <= acc_be;
                        wdata_q  <= acc_wdata;
                        lo_q     <= '0;
                        hi_q     <= '0;
                        state_q  <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    lo_q <= win_lo_d;
                    if (split_q) state_q <= S_BEAT1;
                end
                S_BEAT1: begin
                    hi_q <= win_hi_d;
                end
                S_WAIT: begin
                    if (wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                end
                S_RESP: begin
                    if (bus.i_Rsp_Ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_split_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (go_wait) begin
                state_q    <= S_WAIT;
                wait_cnt_q <= CNT_W'(READ_LATENCY - 2);
            end
            if (go_resp) begin
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= load_val;
                rsp_err_q   <= err_q;
                rsp_split_q <= split_q;
            end
        end
    end

    assign bus.o_Req_Ready = ready_q;
    assign bus.o_Rsp_Valid = rsp_valid_q;
    assign bus.o_Rsp_Data  = rsp_data_q;
    assign bus.o_Rsp_Error = rsp_err_q;
    assign bus.o_Rsp_Split = rsp_split_q;
endmodule
